// File: rtl/inv_round_key_mix_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_round_key_mix_stage_if
//  Description : Handshake and data bundle for the AES-128 inverse round-tail
//                stage. Carries the input beat from inverse SubBytes, the
//                round-key request and response, and the registered result.
//  Ports       : in_valid/in_ready/state_in  - input beat handshake
//                rk_index/rk_in              - round-key request / key
//                out_valid/out_ready         - output handshake
//                state_out/round_out/last    - held result and its tags
//  Revision    : 1.0 - initial release
// ============================================================================
interface inv_round_key_mix_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [3:0]   rk_index;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   round_out;
    logic         last;

    // Stage side: consumes beats and keys, produces results.
    modport slave (
        input  in_valid, state_in, rk_in, out_ready,
        output in_ready, rk_index, out_valid, state_out, round_out, last
    );

    // Environment side: supplies beats and keys, consumes results.
    modport master (
        output in_valid, state_in, rk_in, out_ready,
        input  in_ready, rk_index, out_valid, state_out, round_out, last
    );
endinterface
`default_nettype wire

// File: rtl/inv_round_key_mix_stage.sv
`default_nettype none
// ============================================================================
//  Module      : inv_round_key_mix_stage
//  Description : Registered round tail of the iterative AES-128 inverse
//                cipher. Each accepted beat is XORed with round key K[rc]
//                and passed through InvMixColumns (skipped in the final
//                round), then held in an output register behind a
//                valid/ready handshake. A down-counting round counter
//                selects the key and tags the final round of each block.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset
//                bus   - slave view of inv_round_key_mix_stage_if
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_round_key_mix_stage (
    input wire clk,
    input wire reset,
    inv_round_key_mix_stage_if.slave bus
);

    localparam logic [3:0] c_FIRST_ROUND = 4'd9;

    // ------------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column: coefficients 0e/0b/0d/09 all built from a, 2a, 4a, 8a.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic [3:0]   r_rc;
    logic         r_out_valid;
    logic [127:0] r_state_out;
    logic [3:0]   r_round_out;
    logic         r_last;

    logic         w_in_ready;
    logic         w_accept;
    logic [3:0]   w_rc_eff;
    logic         w_final;
    logic [127:0] w_keyed;
    logic [127:0] w_mixed;

    // No skid buffer: readiness is passed straight back from downstream.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Out-of-range counter values fold back to the first round.
    assign w_rc_eff = (r_rc > c_FIRST_ROUND) ? c_FIRST_ROUND : r_rc;
    assign w_final  = (w_rc_eff == 4'd0);

    assign w_keyed = bus.state_in ^ bus.rk_in;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mixed[127-32*c -: 32] = inv_mix_column(w_keyed[127-32*c -: 32]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rc        <= c_FIRST_ROUND;
            r_out_valid <= 1'b0;
            r_state_out <= '0;
            r_round_out <= 4'd0;
            r_last      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_round_out <= w_rc_eff;
            r_last      <= w_final;
            if (w_final) begin
                r_state_out <= w_keyed;
                r_rc        <= c_FIRST_ROUND;
            end else begin
                r_state_out <= w_mixed;
                r_rc        <= w_rc_eff - 4'd1;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rk_index  = r_rc;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state_out;
    assign bus.round_out = r_round_out;
    assign bus.last      = r_last;

endmodule
`default_nettype wire
